// File: rtl/regbank_access_arbiter.sv
// Two-port arbiter that owns a small single-port register bank.
// Every access runs as grant -> memory cycle -> registered read return.
module regbank_access_arbiter #(
  parameter int AW         = 2,
  parameter int DW         = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [7:0]    coll_cnt
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  state_t        state_q;
  logic          lastB_q;
  logic          capWe_q;
  logic [AW-1:0] capAddr_q;
  logic [DW-1:0] capWdata_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          aGnt_q;
  logic          bGnt_q;
  logic          aRvalid_q;
  logic          bRvalid_q;
  logic [DW-1:0] aRdata_q;
  logic [DW-1:0] bRdata_q;
  logic [7:0]    collCnt_q;

  logic tieA;
  logic goA;
  logic goB;
  logic contended;

  // A wins a tie when priority is fixed, or when B was the last port served.
  assign tieA      = (FIXED_PRIO != 0) || lastB_q;
  assign contended = (state_q == IDLE) && a_req && b_req;

  // While serving one port its own req is ignored, since it is still dropping it.
  always_comb begin
    goA = 1'b0;
    goB = 1'b0;
    unique case (state_q)
      IDLE: begin
        goA = a_req && (!b_req || tieA);
        goB = b_req && !goA;
      end
      SERVE_A: goB = b_req;
      SERVE_B: goA = a_req;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lastB_q    <= 1'b1;
      capWe_q    <= 1'b0;
      capAddr_q  <= '0;
      capWdata_q <= '0;
      aGnt_q     <= 1'b0;
      bGnt_q     <= 1'b0;
      aRvalid_q  <= 1'b0;
      bRvalid_q  <= 1'b0;
      aRdata_q   <= '0;
      bRdata_q   <= '0;
      collCnt_q  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= goA ? SERVE_A : (goB ? SERVE_B : IDLE);
      aGnt_q    <= goA;
      bGnt_q    <= goB;
      aRvalid_q <= 1'b0;
      bRvalid_q <= 1'b0;

      if (goA || goB) begin
        lastB_q    <= goB;
        capWe_q    <= goA ? a_we    : b_we;
        capAddr_q  <= goA ? a_addr  : b_addr;
        capWdata_q <= goA ? a_wdata : b_wdata;
      end

      if (contended && (collCnt_q != 8'hFF)) begin
        collCnt_q <= collCnt_q + 8'd1;
      end

      // The captured access is performed during the SERVE cycle, even if req has dropped.
      if (state_q != IDLE) begin
        if (capWe_q) begin
          mem_q[capAddr_q] <= capWdata_q;
        end else if (state_q == SERVE_A) begin
          aRvalid_q <= 1'b1;
          aRdata_q  <= mem_q[capAddr_q];
        end else begin
          bRvalid_q <= 1'b1;
          bRdata_q  <= mem_q[capAddr_q];
        end
      end
    end
  end

  assign a_gnt    = aGnt_q;
  assign b_gnt    = bGnt_q;
  assign a_rvalid = aRvalid_q;
  assign b_rvalid = bRvalid_q;
  assign a_rdata  = aRdata_q;
  assign b_rdata  = bRdata_q;
  assign coll_cnt = collCnt_q;

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Scoreboard bench: a round-robin instance carries the main traffic,
// a fixed-priority instance is used only for the priority scenario.
module tb_regbank_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [1:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata, coll_cnt;

  logic       fa_req, fb_req;
  logic       fa_gnt, fa_rvalid, fb_gnt, fb_rvalid;
  logic [7:0] fa_rdata, fb_rdata, f_coll_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model [4];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [7:0] expA, expB;

  always #5 clk = ~clk;

  regbank_access_arbiter #(.AW(2), .DW(8), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .coll_cnt(coll_cnt)
  );

  regbank_access_arbiter #(.AW(2), .DW(8), .FIXED_PRIO(1)) dutFp (
    .clk(clk), .rst(rst),
    .a_req(fa_req), .a_we(1'b0), .a_addr(2'd0), .a_wdata(8'd0),
    .a_gnt(fa_gnt), .a_rvalid(fa_rvalid), .a_rdata(fa_rdata),
    .b_req(fb_req), .b_we(1'b0), .b_addr(2'd0), .b_wdata(8'd0),
    .b_gnt(fb_gnt), .b_rvalid(fb_rvalid), .b_rdata(fb_rdata),
    .coll_cnt(f_coll_cnt)
  );

  // Read returns are popped from the per-port expectation queues on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_rvalid) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("[TB] FAIL a_rdata_sb: unexpected a_rvalid, got %0h", a_rdata);
        end else begin
          expA = qa.pop_front();
          if (a_rdata !== expA) begin
            errors++;
            $display("[TB] FAIL a_rdata_sb: got %0h expected %0h", a_rdata, expA);
          end
        end
      end
      if (b_rvalid) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("[TB] FAIL b_rdata_sb: unexpected b_rvalid, got %0h", b_rdata);
        end else begin
          expB = qb.pop_front();
          if (b_rdata !== expB) begin
            errors++;
            $display("[TB] FAIL b_rdata_sb: got %0h expected %0h", b_rdata, expB);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single uncontended access from IDLE; checks gnt after 1 cycle and rvalid after 2.
  task automatic access(input logic portB, input logic we, input logic [1:0] addr,
                        input logic [7:0] wd);
    int   n;
    logic gnt;
    logic rv;
    if (portB) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    if (we) model[addr] = wd;
    else if (portB) qb.push_back(model[addr]);
    else qa.push_back(model[addr]);
    tick();
    n   = 1;
    gnt = portB ? b_gnt : a_gnt;
    while (!gnt && n < 8) begin
      tick();
      n++;
      gnt = portB ? b_gnt : a_gnt;
    end
    checks++;
    if (gnt !== 1'b1 || n != 1) begin
      errors++;
      $display("[TB] FAIL gnt_latency port%s: got gnt=%b after %0d cycles, expected 1 after 1",
               portB ? "B" : "A", gnt, n);
    end
    if (portB) b_req = 1'b0;
    else a_req = 1'b0;
    tick();
    rv = portB ? b_rvalid : a_rvalid;
    checks++;
    if (rv !== ~we) begin
      errors++;
      $display("[TB] FAIL rvalid_timing port%s: got %b expected %b", portB ? "B" : "A", rv, ~we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 2'd0; a_wdata = 8'd0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 2'd0; b_wdata = 8'd0;
    fa_req = 1'b0; fb_req = 1'b0;
    qa.delete(); qb.delete();
    for (int i = 0; i < 4; i++) model[i] = 8'd0;
    tick();
    tick();
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {a_gnt, b_gnt, a_rvalid, b_rvalid});
    end
    checks++;
    if ({a_rdata, b_rdata, coll_cnt} !== 24'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 000000", {a_rdata, b_rdata, coll_cnt});
    end
    checks++;
    if ({fa_gnt, fb_gnt, f_coll_cnt} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_fp: got %h expected 0", {fa_gnt, fb_gnt, f_coll_cnt});
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 2'(i), 8'd0);
    checks++;
    if (coll_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_coll: got %0d expected 0", coll_cnt);
    end
  endtask

  task automatic test_write_read();
    access(1'b0, 1'b1, 2'd2, 8'h5A);
    access(1'b1, 1'b0, 2'd2, 8'h00);
  endtask

  task automatic test_tie_rr();
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd2;
    b_req = 1'b1; b_we = 1'b0; b_addr = 2'd1;
    for (int i = 0; i < 3; i++) begin
      qa.push_back(model[2]);
      qb.push_back(model[1]);
    end
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (a_gnt !== (i % 2 == 1) || b_gnt !== (i % 2 == 0)) begin
        errors++;
        $display("[TB] FAIL tie_order cycle %0d: got a=%b b=%b expected a=%b b=%b",
                 i, a_gnt, b_gnt, (i % 2 == 1), (i % 2 == 0));
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (coll_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL tie_coll: got %0d expected 1", coll_cnt);
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("[TB] FAIL tie_drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
  endtask

  task automatic test_back_to_back();
    a_req = 1'b1; a_we = 1'b1; a_addr = 2'd3; a_wdata = 8'hC3;
    model[3] = 8'hC3;
    tick();
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_first: got a=%b b=%b expected a=1 b=0", a_gnt, b_gnt);
    end
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 2'd3;
    qb.push_back(model[3]);
    tick();
    checks++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second: got a=%b b=%b expected a=0 b=1", a_gnt, b_gnt);
    end
    b_req = 1'b0;
    tick();
    checks++;
    if (b_rvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_rvalid: got %b expected 1", b_rvalid);
    end
    tick();
  endtask

  task automatic test_fixed_prio();
    for (int r = 0; r < 3; r++) begin
      fa_req = 1'b1;
      tick();
      fa_req = 1'b0;
      tick();
      fa_req = 1'b1;
      fb_req = 1'b1;
      tick();
      checks++;
      if (fa_gnt !== 1'b1 || fb_gnt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fp_tie rep %0d: got a=%b b=%b expected a=1 b=0", r, fa_gnt, fb_gnt);
      end
      fa_req = 1'b0;
      tick();
      checks++;
      if (fb_gnt !== 1'b1 || fa_gnt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fp_slot rep %0d: got a=%b b=%b expected a=0 b=1", r, fa_gnt, fb_gnt);
      end
      fb_req = 1'b0;
      tick();
    end
    checks++;
    if (f_coll_cnt !== 8'd3) begin
      errors++;
      $display("[TB] FAIL fp_coll: got %0d expected 3", f_coll_cnt);
    end
  endtask

  task automatic test_reset_in_serve();
    a_req = 1'b1; a_we = 1'b1; a_addr = 2'd1; a_wdata = 8'hFF;
    tick();
    checks++;
    if (a_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_serve_gnt: got %b expected 1", a_gnt);
    end
    rst = 1'b1;
    qa.delete(); qb.delete();
    for (int i = 0; i < 4; i++) model[i] = 8'd0;
    tick();
    checks++;
    if (a_gnt !== 1'b0 || a_rvalid !== 1'b0 || coll_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL rst_serve_flush: got gnt=%b rvalid=%b coll=%0d expected 0 0 0",
               a_gnt, a_rvalid, coll_cnt);
    end
    a_req = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (a_gnt !== 1'b0 || a_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_serve_late: got gnt=%b rvalid=%b expected 0 0", a_gnt, a_rvalid);
    end
    a_req = 1'b1; a_we = 1'b0; a_addr = 2'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 2'd1;
    qa.push_back(model[1]);
    tick();
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_rr_first: got a=%b b=%b expected a=1 b=0", a_gnt, b_gnt);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    tick();
    access(1'b0, 1'b0, 2'd1, 8'h00);
  endtask

  task automatic test_coll_saturate();
    a_we = 1'b1; a_addr = 2'd0; a_wdata = 8'd0;
    b_we = 1'b1; b_addr = 2'd0; b_wdata = 8'd0;
    for (int i = 0; i < 300; i++) begin
      a_req = 1'b1;
      b_req = 1'b1;
      tick();
      a_req = 1'b0;
      b_req = 1'b0;
      tick();
      if (i == 252) begin
        checks++;
        if (coll_cnt !== 8'd254) begin
          errors++;
          $display("[TB] FAIL coll_254: got %0d expected 254", coll_cnt);
        end
      end
      if (i == 253) begin
        checks++;
        if (coll_cnt !== 8'd255) begin
          errors++;
          $display("[TB] FAIL coll_255: got %0d expected 255", coll_cnt);
        end
      end
    end
    checks++;
    if (coll_cnt !== 8'd255) begin
      errors++;
      $display("[TB] FAIL coll_sat: got %0d expected 255", coll_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie_rr();
    test_back_to_back();
    test_fixed_prio();
    test_reset_in_serve();
    test_coll_saturate();
    tick(); tick();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("[TB] FAIL final_drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
